// File: rtl/sram_arb_pkg.sv
// ============================================================================
// sram_arb_pkg: shared types and helpers for the SRAM port arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sram_arb_pkg;

    // Requester ids are carried at a fixed width; supports up to 256 ports.
    localparam int unsigned c_ID_W = 8;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic              valid;
        logic [c_ID_W-1:0] id;
    } resp_pipe_t;

    function automatic int unsigned addr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_rr_arbiter.sv
// ============================================================================
// sram_rr_arbiter: combinational round-robin pick, scanning upward from ptr+1.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned NumReq = 4
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [c_ID_W-1:0] ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [c_ID_W-1:0] idx_o
);

    logic w_found;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        w_found = 1'b0;
        // Indices above the pointer win first, then the scan wraps to 0..ptr.
        for (int k = 0; k < int'(NumReq); k++) begin
            if (!w_found && req_i[k] && (c_ID_W'(k) > ptr_i)) begin
                w_found  = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = c_ID_W'(k);
            end
        end
        for (int k = 0; k < int'(NumReq); k++) begin
            if (!w_found && req_i[k] && (c_ID_W'(k) <= ptr_i)) begin
                w_found  = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = c_ID_W'(k);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sram_port_arbiter.sv
// ============================================================================
// sram_port_arbiter: round-robin sharing of one SRAM port with read routing.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned NumReq       = 4,
    parameter int unsigned NumWords     = 1024,
    parameter int unsigned DataWidth    = 64,
    parameter int unsigned ByteWidth    = 8,
    parameter int unsigned Latency      = 1,
    parameter bit          ClearOnReset = 1'b1,
    localparam int unsigned AddrWidth   = addr_width(NumWords),
    localparam int unsigned BeWidth     = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NumReq-1:0]                  req_i,
    input  logic [NumReq-1:0]                  we_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]   addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0]   wdata_i,
    input  logic [NumReq-1:0][BeWidth-1:0]     be_i,
    output logic [NumReq-1:0]                  gnt_o,
    output logic [NumReq-1:0]                  rvalid_o,
    output logic [DataWidth-1:0]               rdata_o,
    output logic                               init_done_o,
    output logic                               sram_req_o,
    output logic                               sram_we_o,
    output logic [AddrWidth-1:0]               sram_addr_o,
    output logic [DataWidth-1:0]               sram_wdata_o,
    output logic [BeWidth-1:0]                 sram_be_o,
    input  logic [DataWidth-1:0]               sram_rdata_i
);

    localparam logic [AddrWidth-1:0] c_LAST_ADDR = AddrWidth'(NumWords - 1);
    localparam logic [c_ID_W-1:0]    c_PTR_RST   = c_ID_W'(NumReq - 1);

    arb_state_e                 state_q, state_d;
    logic [AddrWidth-1:0]       clr_cnt_q, clr_cnt_d;
    logic [c_ID_W-1:0]          ptr_q, ptr_d;
    resp_pipe_t [Latency-1:0]   pipe_q, pipe_d;

    logic [NumReq-1:0]          w_arb_gnt;
    logic [c_ID_W-1:0]          w_arb_idx;
    logic                       w_read_grant;

    sram_rr_arbiter #(
        .NumReq (NumReq)
    ) u_rr (
        .req_i  (req_i),
        .ptr_i  (ptr_q),
        .gnt_o  (w_arb_gnt),
        .idx_o  (w_arb_idx)
    );

    // Outputs are held at zero while reset is asserted.
    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        ptr_d        = ptr_q;
        gnt_o        = '0;
        init_done_o  = 1'b0;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        w_read_grant = 1'b0;
        if (!rst_i) begin
            unique case (state_q)
                ST_CLEAR: begin
                    sram_req_o  = 1'b1;
                    sram_we_o   = 1'b1;
                    sram_addr_o = clr_cnt_q;
                    sram_be_o   = '1;
                    clr_cnt_d   = clr_cnt_q + 1'b1;
                    if (clr_cnt_q == c_LAST_ADDR) begin
                        state_d   = ST_RUN;
                        clr_cnt_d = '0;
                    end
                end
                ST_RUN: begin
                    init_done_o = 1'b1;
                    gnt_o       = w_arb_gnt;
                    sram_req_o  = |req_i;
                    for (int k = 0; k < int'(NumReq); k++) begin
                        if (w_arb_gnt[k]) begin
                            sram_we_o    = we_i[k];
                            sram_addr_o  = addr_i[k];
                            sram_wdata_o = wdata_i[k];
                            sram_be_o    = be_i[k];
                            w_read_grant = !we_i[k];
                        end
                    end
                    if (|req_i) begin
                        ptr_d = w_arb_idx;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = '{valid: w_read_grant, id: w_arb_idx};
        for (int i = 1; i < int'(Latency); i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_comb begin
        rvalid_o = '0;
        for (int k = 0; k < int'(NumReq); k++) begin
            rvalid_o[k] = !rst_i && pipe_q[Latency-1].valid
                          && (pipe_q[Latency-1].id == c_ID_W'(k));
        end
    end

    assign rdata_o = sram_rdata_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if (ClearOnReset) begin
                state_q <= ST_CLEAR;
            end else begin
                state_q <= ST_RUN;
            end
            clr_cnt_q <= '0;
            ptr_q     <= c_PTR_RST;
            pipe_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ptr_q     <= ptr_d;
            pipe_q    <= pipe_d;
        end
    end

endmodule

`default_nettype wire
